seq_alu: RTL
============

# seq_alu

Parametrised, handshaked successor to the team's 4-bit combinational ALU. It keeps the M/S mode split (M=0 logic, M=1 arithmetic) and adds:
- generic WIDTH;
- shift and rotate operations;
- an iterative shift-add multiplier;
- registered results with flags (zero, signed overflow);
- valid/ready handshakes on input and output.

It sits between the datapath register file and the writeback stage. It holds one operation in flight at a time.

## Interface
- WIDTH, 8: operand/result width. Must be a power of two, ≥ 2.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; equals (state == IDLE)
- a, b  in  WIDTH  operands
- cin  in  1  carry/borrow in; used only by ADD/SUB
- m  in  1  0 = logic, 1 = arithmetic
- s  in  3  operation select
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer accepts the result
- f  out  WIDTH  result (low half for MUL)
- f_hi  out  WIDTH  high half of MUL product; 0 for all other ops
- cout  out  1  carry / borrow out
- zero  out  1  {f_hi,f} == 0
- ovf  out  1  overflow flag

## Operation
- **Logic, m=0.** cout=0 and ovf=0 for every logic op.
  - s=000: f = ~a
  - s=001: f = a & b
  - s=010: f = a | b
  - s=011: f = a ^ b
  - s=100: SHL, f = a << sh
  - s=101: SHR, logical right shift by sh
  - s=110: SAR, arithmetic right shift by sh
  - s=111: ROL, rotate left by sh
  - sh = b[$clog2(WIDTH)-1:0], i.e. the shift amount is taken modulo WIDTH.
- **Arithmetic, m=1.**
  - s=000 ADD: {cout,f} = a + b + cin, computed at WIDTH+1 bits. ovf = signed overflow.
  - s=001 SUB: {cout,f} = a − b − cin, computed at WIDTH+1 bits. cout=1 means borrow (a < b+cin, unsigned). ovf = signed overflow.
  - s=010 MUL: unsigned product {f_hi,f} = a × b. cin is ignored, cout=0, ovf = (f_hi != 0).
  - s=011..111: reserved. Result is f=0, f_hi=0, cout=0, ovf=0, zero=1, delivered with single-cycle latency.
- **State machine.** States are IDLE, MUL, DONE.
  - IDLE:
    - in_valid=1 with a non-MUL op: compute, register all outputs, go to DONE.
    - in_valid=1 with MUL: latch a and b, clear the accumulator, set count=0, go to MUL.
  - MUL: one shift-add step per cycle. When count reaches WIDTH−1, register the product and flags, then go to DONE.
  - DONE: out_valid=1. When out_ready=1 at a clock edge, go to IDLE.
- Operands are captured only at the accept edge. Input changes afterwards do not affect the result.
- in_valid while in_ready=0 is ignored. Requests are not queued.
- Outputs f, f_hi, cout, zero, ovf change only at a result-register edge. They stay stable through DONE regardless of out_ready.

## Timing
- Reset (async, takes effect immediately):
  - state=IDLE, count=0;
  - f, f_hi, cout, zero, ovf, out_valid = 0;
  - in_ready=1 once rst deasserts.
- Accept edge E0 is the rising edge where in_valid && in_ready.
- Non-MUL latency: out_valid=1 from E0 onward, i.e. 1 cycle.
- MUL latency: out_valid=1 from edge E0+WIDTH onward, i.e. WIDTH cycles. in_ready=0 throughout.
- Result leaves at the first edge in DONE with out_ready=1. out_valid falls and in_ready rises after that edge.
- Minimum initiation interval is 2 cycles, since there is no accept in DONE.
- out_ready=1 while not in DONE has no effect.
- rst asserted mid-MUL or in DONE aborts the operation. The result is discarded and all outputs are zeroed.

## Test plan
- **ADD, WIDTH=8.** a=0xF0, b=0x20, cin=1 → f=0x11, cout=1, ovf=0, zero=0. out_valid appears the cycle after accept.
- **SUB.** a=0x05, b=0x07, cin=0 → f=0xFE, cout=1, ovf=0. Then a=0x80, b=0x01 → f=0x7F, cout=0, ovf=1.
- **MUL.** a=0xFF, b=0xFF → f=0x01, f_hi=0xFE, ovf=1. out_valid rises exactly 8 edges after accept, and in_ready=0 throughout.
- **Shifts.** a=0x81, b=0x09 (sh=1):
  - SHR → 0x40
  - SAR → 0xC0
  - ROL → 0x03
  - SHL → 0x02, cout=0
- **Backpressure.** Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a → outputs stay constant, in_ready stays 0, and no second op is accepted. Raise out_ready → IDLE the next cycle.
- **Reset mid-MUL.** Assert rst 3 cycles into a MUL → outputs are 0 immediately. After release, a fresh ADD 0x01+0x01 gives f=0x02.

Source files
------------

// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle between the register file side
// (master) and the sequential ALU (slave).
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             m;
  logic [2:0]       s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] f_hi;
  logic             cout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, m, s, out_ready,
    input  in_ready, out_valid, f, f_hi, cout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, m, s, out_ready,
    output in_ready, out_valid, f, f_hi, cout, zero, ovf
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: logic/shift ops and ADD/SUB finish in one cycle, MUL is an
// iterative shift-add taking WIDTH cycles. One operation in flight; the
// result is held in registers until the consumer takes it.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  seq_alu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SHW-1:0]     count;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;

  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic               is_mul;
  logic               last_step;

  logic [WIDTH-1:0]   res_f;
  logic               res_cout;
  logic               res_ovf;

  assign sh        = bus.b[SHW-1:0];
  assign sum       = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
  assign diff      = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.cin};
  assign is_mul    = bus.m && (bus.s == 3'b010);
  assign last_step = (count == SHW'(WIDTH - 1));

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);

  // Single-cycle result for every op except MUL; reserved codes give zero.
  always_comb begin
    res_f    = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    if (!bus.m) begin
      case (bus.s)
        3'b000: res_f = ~bus.a;
        3'b001: res_f = bus.a & bus.b;
        3'b010: res_f = bus.a | bus.b;
        3'b011: res_f = bus.a ^ bus.b;
        3'b100: res_f = bus.a << sh;
        3'b101: res_f = bus.a >> sh;
        3'b110: res_f = $signed(bus.a) >>> sh;
        default: res_f = (bus.a << sh) | (bus.a >> (WIDTH - int'(sh)));
      endcase
    end else begin
      case (bus.s)
        3'b000: begin
          res_f    = sum[WIDTH-1:0];
          res_cout = sum[WIDTH];
          res_ovf  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                     (sum[WIDTH-1] != bus.a[WIDTH-1]);
        end
        3'b001: begin
          res_f    = diff[WIDTH-1:0];
          res_cout = diff[WIDTH];
          res_ovf  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                     (diff[WIDTH-1] != bus.a[WIDTH-1]);
        end
        default: begin
          res_f    = '0;
          res_cout = 1'b0;
          res_ovf  = 1'b0;
        end
      endcase
    end
  end

  // Partial product for the current multiplier bit.
  always_comb begin
    acc_step = acc + (mplier[0] ? mcand : '0);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept only in IDLE, leave DONE when the result is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = is_mul ? MUL : DONE;
      MUL:     if (last_step) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiplier datapath and result registers; results only move on a
  // completion edge so they stay stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      bus.f    <= '0;
      bus.f_hi <= '0;
      bus.cout <= 1'b0;
      bus.zero <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_mul) begin
              mcand  <= {{WIDTH{1'b0}}, bus.a};
              mplier <= bus.b;
              acc    <= '0;
              count  <= '0;
            end else begin
              bus.f    <= res_f;
              bus.f_hi <= '0;
              bus.cout <= res_cout;
              bus.zero <= (res_f == '0);
              bus.ovf  <= res_ovf;
            end
          end
        end
        MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (last_step) begin
            bus.f    <= acc_step[WIDTH-1:0];
            bus.f_hi <= acc_step[2*WIDTH-1:WIDTH];
            bus.cout <= 1'b0;
            bus.zero <= (acc_step == '0);
            bus.ovf  <= |acc_step[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule
